// File: rtl/seq_cla_subtractor16.sv
// Multi-cycle subtractor: diff = A - B computed as A + ~B + 1, one nibble per clock
// through a single shared 4-bit carry-lookahead slice, LSB nibble first.
module seq_cla_subtractor16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  areg_q, areg_d;
  logic [WIDTH-1:0]  breg_q, breg_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_q, borrow_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Shared 4-bit CLA slice
  logic [3:0] nib_a, nib_b, nib_g, nib_p, nib_sum;
  logic [4:0] nib_c;
  logic       grp_g, grp_p;

  always_comb begin
    nib_a    = areg_q[{idx_q, 2'b00} +: 4];
    nib_b    = ~breg_q[{idx_q, 2'b00} +: 4];
    nib_g    = nib_a & nib_b;
    nib_p    = nib_a ^ nib_b;
    nib_c[0] = carry_q;
    nib_c[1] = nib_g[0] | (nib_p[0] & carry_q);
    nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & carry_q);
    nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
             | (nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
    grp_g    = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
             | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0]);
    grp_p    = &nib_p;
    nib_c[4] = grp_g | (grp_p & carry_q);
    nib_sum  = nib_p ^ nib_c[3:0];
  end

  always_comb begin
    state_d  = state_q;
    areg_d   = areg_q;
    breg_d   = breg_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          areg_d  = A;
          breg_d  = B;
          acc_d   = '0;
          carry_d = 1'b1;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d[{idx_q, 2'b00} +: 4] = nib_sum;
        carry_d = nib_c[4];
        idx_d   = idx_q + 1'b1;
        if (idx_q == IdxW'(NIB - 1)) begin
          diff_d   = acc_d;
          borrow_d = ~nib_c[4];
          ovf_d    = (areg_q[WIDTH-1] != breg_q[WIDTH-1]) & (acc_d[WIDTH-1] != areg_q[WIDTH-1]);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      areg_q   <= '0;
      breg_q   <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      areg_q   <= areg_d;
      breg_q   <= breg_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_cla_subtractor16.sv
// Directed-vector bench for seq_cla_subtractor16 (WIDTH=16); inputs change and
// outputs are sampled on the falling clock edge.
module tb_seq_cla_subtractor16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A, B;
  logic [15:0] diff;
  logic        borrow_out, overflow, busy, done;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [15:0] last_diff;

  seq_cla_subtractor16 #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A          (A),
    .B          (B),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Launch one op, check busy window, stable diff during run, then the result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ed, input logic eb, input logic eo);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = ~a; B = ~b;
    check_eq({tag, "_busy_t"}, 32'(busy), 32'd1);
    check_eq({tag, "_done_t"}, 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq({tag, "_busy_run"}, 32'(busy), 32'd1);
      check_eq({tag, "_done_run"}, 32'(done), 32'd0);
      check_eq({tag, "_diff_hold"}, 32'(diff), 32'(last_diff));
    end
    @(negedge clk);
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
    check_eq({tag, "_diff"}, 32'(diff), 32'(ed));
    check_eq({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
    check_eq({tag, "_ovf"}, 32'(overflow), 32'(eo));
    @(negedge clk);
    check_eq({tag, "_done_drop"}, 32'(done), 32'd0);
    check_eq({tag, "_diff_keep"}, 32'(diff), 32'(ed));
    last_diff = ed;
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; A = 16'h1111; B = 16'h2222;
    last_diff = 16'h0000;
    repeat (2) @(negedge clk);
    check_eq("rst_diff", 32'(diff), 32'h0);
    check_eq("rst_borrow", 32'(borrow_out), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_done", 32'(done), 32'd0);

    run_op("basic", 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);
    run_op("wrap",  16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
    run_op("sovf",  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);

    // start held high; operands change after acceptance
    @(negedge clk);
    A = 16'h00F0; B = 16'h000F; start = 1'b1;
    @(negedge clk);                       // after edge t
    A = 16'hFFFF; B = 16'h0000;
    check_eq("hold_busy_t", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);            // after t+3
    check_eq("hold_busy_t3", 32'(busy), 32'd1);
    @(negedge clk);                       // after t+4
    check_eq("hold_done1", 32'(done), 32'd1);
    check_eq("hold_diff1", 32'(diff), 32'h00E1);
    check_eq("hold_borrow1", 32'(borrow_out), 32'd0);
    @(negedge clk);                       // after t+5: back in idle, start in DONE ignored
    check_eq("hold_idle_busy", 32'(busy), 32'd0);
    check_eq("hold_idle_done", 32'(done), 32'd0);
    @(negedge clk);                       // after t+6: accepted in idle
    check_eq("hold_reaccept", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("hold_busy2", 32'(busy), 32'd1);
    check_eq("hold_diff_stable", 32'(diff), 32'h00E1);
    @(negedge clk);                       // after t+10
    start = 1'b0;
    check_eq("hold_done2", 32'(done), 32'd1);
    check_eq("hold_diff2", 32'(diff), 32'hFFFF);
    check_eq("hold_borrow2", 32'(borrow_out), 32'd0);
    check_eq("hold_ovf2", 32'(overflow), 32'd0);
    @(negedge clk);
    check_eq("hold_done2_drop", 32'(done), 32'd0);
    last_diff = 16'hFFFF;

    // mid-run abort
    @(negedge clk);
    A = 16'h5555; B = 16'h1111; start = 1'b1;
    @(negedge clk);                       // after edge t
    start = 1'b0;
    @(negedge clk);                       // after t+1
    rst = 1'b0;
    @(negedge clk);                       // after t+2 (reset)
    rst = 1'b1;
    check_eq("abort_diff", 32'(diff), 32'h0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_borrow", 32'(borrow_out), 32'd0);
    check_eq("abort_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("abort_no_done", 32'(done), 32'd0);
    end
    last_diff = 16'h0000;

    run_op("negm1", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);
    run_op("equal", 16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
